// File: rtl/as_gpio_arb.sv
// Round-robin arbiter between core and debug GPIO writers.
// Drives a registered address/data/cs burst for HOLD_CYC cycles per grant.
module as_gpio_arb #(
  parameter int NR_GPIOS = 8,
  parameter int ADDR_W   = 8,
  parameter int HOLD_CYC = 2
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                creq_i,
  input  logic [ADDR_W-1:0]   caddr_i,
  input  logic [NR_GPIOS-1:0] cdata_i,
  output logic                cack_o,
  input  logic                dreq_i,
  input  logic [ADDR_W-1:0]   daddr_i,
  input  logic [NR_GPIOS-1:0] ddata_i,
  output logic                dack_o,
  output logic [NR_GPIOS-1:0] gpio_o,
  output logic [ADDR_W-1:0]   gpioAddr_o,
  output logic                cs_o,
  output logic                busy_o
);

  localparam logic [0:0] IDLE  = 1'b0;
  localparam logic [0:0] DRIVE = 1'b1;

  localparam logic [3:0] HOLD_LD = 4'(HOLD_CYC - 1);

  logic [0:0]          state;
  logic [3:0]          cnt;
  logic                last_d;
  logic                gnt_c;
  logic                gnt_d;
  logic [ADDR_W-1:0]   sel_addr;
  logic [NR_GPIOS-1:0] sel_data;

  // last_d=1 means debug won last, so core wins a tie
  always_comb begin
    gnt_c = creq_i & (~dreq_i | last_d);
    gnt_d = dreq_i & ~gnt_c;
  end

  always_comb begin
    sel_addr = caddr_i;
    sel_data = cdata_i;
    unique case (1'b1)
      gnt_c: begin
        sel_addr = caddr_i;
        sel_data = cdata_i;
      end
      gnt_d: begin
        sel_addr = daddr_i;
        sel_data = ddata_i;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state      <= IDLE;
      cnt        <= 4'd0;
      last_d     <= 1'b1;
      cack_o     <= 1'b0;
      dack_o     <= 1'b0;
      cs_o       <= 1'b0;
      busy_o     <= 1'b0;
      gpio_o     <= '0;
      gpioAddr_o <= '0;
    end else begin
      cack_o <= 1'b0;
      dack_o <= 1'b0;
      case (state)
        IDLE: begin
          if (gnt_c | gnt_d) begin
            state      <= DRIVE;
            cnt        <= HOLD_LD;
            last_d     <= gnt_d;
            cack_o     <= gnt_c;
            dack_o     <= gnt_d;
            cs_o       <= 1'b1;
            busy_o     <= 1'b1;
            gpio_o     <= sel_data;
            gpioAddr_o <= sel_addr;
          end
        end
        DRIVE: begin
          if (cnt == 4'd0) begin
            state  <= IDLE;
            cs_o   <= 1'b0;
            busy_o <= 1'b0;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        default: begin
          state  <= IDLE;
          cs_o   <= 1'b0;
          busy_o <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_as_gpio_arb.sv
// Directed vector bench for as_gpio_arb.
// Main DUT uses HOLD_CYC=2; two extra instances cover HOLD_CYC=1 and 16.
module tb_as_gpio_arb;

  logic       clk = 1'b0;
  logic       rst;
  logic       creq, dreq;
  logic [7:0] caddr, cdata, daddr, ddata;
  logic       cack, dack, cs, busy;
  logic [7:0] gpio, gaddr;

  logic       r1, r16;
  logic       a1, a16, da1, da16, cs1, cs16, b1, b16;
  logic [7:0] g1, g16, ga1, ga16;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  as_gpio_arb #(.NR_GPIOS(8), .ADDR_W(8), .HOLD_CYC(2)) dut (
    .clk_i(clk), .rst_i(rst),
    .creq_i(creq), .caddr_i(caddr), .cdata_i(cdata), .cack_o(cack),
    .dreq_i(dreq), .daddr_i(daddr), .ddata_i(ddata), .dack_o(dack),
    .gpio_o(gpio), .gpioAddr_o(gaddr), .cs_o(cs), .busy_o(busy)
  );

  as_gpio_arb #(.NR_GPIOS(8), .ADDR_W(8), .HOLD_CYC(1)) dut1 (
    .clk_i(clk), .rst_i(rst),
    .creq_i(r1), .caddr_i(8'h01), .cdata_i(8'h11), .cack_o(a1),
    .dreq_i(1'b0), .daddr_i(8'h00), .ddata_i(8'h00), .dack_o(da1),
    .gpio_o(g1), .gpioAddr_o(ga1), .cs_o(cs1), .busy_o(b1)
  );

  as_gpio_arb #(.NR_GPIOS(8), .ADDR_W(8), .HOLD_CYC(16)) dut16 (
    .clk_i(clk), .rst_i(rst),
    .creq_i(r16), .caddr_i(8'h02), .cdata_i(8'h22), .cack_o(a16),
    .dreq_i(1'b0), .daddr_i(8'h00), .ddata_i(8'h00), .dack_o(da16),
    .gpio_o(g16), .gpioAddr_o(ga16), .cs_o(cs16), .busy_o(b16)
  );

  typedef struct {
    logic       rst;
    logic       cr;
    logic [7:0] ca, cd;
    logic       dr;
    logic [7:0] da, dd;
    logic [3:0] f;
    logic [7:0] g, a;
  } vec_t;

  vec_t vq[$];

  task automatic add(input logic r, input logic c, input logic [7:0] ca,
                     input logic [7:0] cd, input logic d,
                     input logic [7:0] da, input logic [7:0] dd,
                     input logic [3:0] f, input logic [7:0] g,
                     input logic [7:0] a);
    vec_t v;
    v.rst = r; v.cr = c; v.ca = ca; v.cd = cd;
    v.dr = d; v.da = da; v.dd = dd;
    v.f = f; v.g = g; v.a = a;
    vq.push_back(v);
  endtask

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  initial begin
    int n1, n16;
    logic ec, ed;
    rst = 1'b1; creq = 0; dreq = 0;
    caddr = 0; cdata = 0; daddr = 0; ddata = 0;
    r1 = 0; r16 = 0;
    repeat (2) @(negedge clk);
    chk("rst_flags", {cack, dack, cs, busy}, 4'b0000);
    chk("rst_gpio", {gpio, gaddr}, 16'h0000);
    rst = 1'b0;

    // f = {cack, dack, cs, busy}
    add(0, 1, 8'h04, 8'h07, 0, 8'h00, 8'h00, 4'b1011, 8'h07, 8'h04);
    add(0, 0, 8'h00, 8'h00, 0, 8'h00, 8'h00, 4'b0011, 8'h07, 8'h04);
    add(0, 0, 8'h00, 8'h00, 0, 8'h00, 8'h00, 4'b0000, 8'h07, 8'h04);
    add(0, 0, 8'h00, 8'h00, 0, 8'h00, 8'h00, 4'b0000, 8'h07, 8'h04);
    add(1, 0, 8'h00, 8'h00, 0, 8'h00, 8'h00, 4'b0000, 8'h00, 8'h00);
    add(0, 1, 8'h04, 8'h07, 1, 8'h05, 8'hA5, 4'b1011, 8'h07, 8'h04);
    add(0, 0, 8'h00, 8'h00, 1, 8'h05, 8'hA5, 4'b0011, 8'h07, 8'h04);
    add(0, 0, 8'h00, 8'h00, 1, 8'h05, 8'hA5, 4'b0000, 8'h07, 8'h04);
    add(0, 0, 8'h00, 8'h00, 1, 8'h05, 8'hA5, 4'b0111, 8'hA5, 8'h05);
    add(0, 0, 8'h00, 8'h00, 0, 8'h00, 8'h00, 4'b0011, 8'hA5, 8'h05);
    add(0, 0, 8'h00, 8'h00, 0, 8'h00, 8'h00, 4'b0000, 8'hA5, 8'h05);
    add(0, 1, 8'h10, 8'h3C, 0, 8'h00, 8'h00, 4'b1011, 8'h3C, 8'h10);
    add(0, 0, 8'h00, 8'h00, 1, 8'h20, 8'h5A, 4'b0011, 8'h3C, 8'h10);
    add(0, 0, 8'h00, 8'h00, 1, 8'h20, 8'h5A, 4'b0000, 8'h3C, 8'h10);
    add(0, 0, 8'h00, 8'h00, 1, 8'h20, 8'h5A, 4'b0111, 8'h5A, 8'h20);
    add(0, 0, 8'h00, 8'h00, 0, 8'h00, 8'h00, 4'b0011, 8'h5A, 8'h20);
    add(0, 0, 8'h00, 8'h00, 0, 8'h00, 8'h00, 4'b0000, 8'h5A, 8'h20);
    add(0, 0, 8'h00, 8'h00, 1, 8'h33, 8'hC3, 4'b0111, 8'hC3, 8'h33);
    add(0, 0, 8'h00, 8'h00, 0, 8'h00, 8'h00, 4'b0011, 8'hC3, 8'h33);
    add(0, 0, 8'h00, 8'h00, 0, 8'h00, 8'h00, 4'b0000, 8'hC3, 8'h33);

    for (int i = 0; i < vq.size(); i++) begin
      @(negedge clk);
      rst = vq[i].rst; creq = vq[i].cr; caddr = vq[i].ca;
      cdata = vq[i].cd; dreq = vq[i].dr; daddr = vq[i].da;
      ddata = vq[i].dd;
      @(posedge clk); #1;
      chk($sformatf("v%0d_flags", i), {cack, dack, cs, busy}, vq[i].f);
      chk($sformatf("v%0d_gpio", i), gpio, vq[i].g);
      chk($sformatf("v%0d_addr", i), gaddr, vq[i].a);
    end
    @(negedge clk);
    rst = 0; creq = 0; dreq = 0;

    // Continuous requests from both; debug won last, so core goes first
    caddr = 8'h01; cdata = 8'h11; daddr = 8'h02; ddata = 8'h22;
    creq = 1; dreq = 1;
    for (int k = 0; k < 18; k++) begin
      @(posedge clk); #1;
      ec = (k % 3 == 0) && ((k / 3) % 2 == 0);
      ed = (k % 3 == 0) && ((k / 3) % 2 == 1);
      chk($sformatf("rr%0d_flags", k), {cack, dack, cs, busy},
          {ec, ed, (k % 3 != 2), (k % 3 != 2)});
      chk($sformatf("rr%0d_gpio", k), gpio,
          ((k / 3) % 2 == 0) ? 8'h11 : 8'h22);
    end
    @(negedge clk);
    creq = 0; dreq = 0;
    repeat (2) @(negedge clk);

    // Reset during second DRIVE cycle, request left high across it
    creq = 1; caddr = 8'h44; cdata = 8'h99;
    @(posedge clk); #1;
    chk("ar_grant", {cack, cs, gpio}, {1'b1, 1'b1, 8'h99});
    @(posedge clk); #1;
    chk("ar_drive2", {cack, cs}, 2'b01);
    @(negedge clk);
    rst = 1; #1;
    chk("ar_async", {cs, busy, cack, gpio, gaddr}, 19'h0);
    @(posedge clk); #1;
    chk("ar_held", {cack, dack, cs}, 3'b000);
    @(negedge clk);
    rst = 0;
    @(posedge clk); #1;
    chk("ar_regrant", {cack, cs, gpio, gaddr}, {2'b11, 8'h99, 8'h44});
    @(negedge clk);
    creq = 0;
    repeat (3) @(negedge clk);

    // Hold-length extremes on the side instances
    r1 = 1; r16 = 1;
    @(posedge clk); #1;
    chk("h_ack", {a1, a16, cs1, cs16}, 4'b1111);
    @(negedge clk);
    r1 = 0; r16 = 0;
    n1 = 1; n16 = 1;
    for (int k = 0; k < 20; k++) begin
      @(posedge clk); #1;
      if (cs1) n1++;
      if (cs16) n16++;
      if (a1 | a16) begin
        errors++;
        $display("FAIL h_extra_ack: got 1 expected 0");
      end
    end
    chk("h1_len", n1, 1);
    chk("h16_len", n16, 16);
    chk("h_gpio", {g1, ga1, g16, ga16}, 32'h1101_2202);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  always @(posedge clk) begin
    #1;
    if (!rst && cack && dack) begin
      checks++;
      errors++;
      $display("FAIL dual_ack: got 11 expected not both");
    end
  end

endmodule
